// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity modes,
// the receive FIFO entry layout and a 3-sample majority vote.
package uart_pkg;

    localparam int MAX_PAYLOAD = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    typedef struct packed {
        logic                   brk;
        logic                   ferr;
        logic                   perr;
        logic [MAX_PAYLOAD-1:0] data;
    } uart_rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-word stream: valid/ready handshake carrying data plus per-word status.
interface uart_rx_os_if #(parameter int PAYLOAD_BITS = 8) ();
    logic                    m_valid;
    logic                    m_ready;
    logic [PAYLOAD_BITS-1:0] m_data;
    logic                    m_perr;
    logic                    m_ferr;
    logic                    m_break;

    modport master (output m_valid, m_data, m_perr, m_ferr, m_break, input m_ready);
    modport slave  (input m_valid, m_data, m_perr, m_ferr, m_break, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: pointers carry an extra wrap bit to tell full from empty.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           push,
    input  uart_rx_entry_t wdata,
    input  logic           pop,
    output uart_rx_entry_t rdata,
    output logic           valid,
    output logic           overrun
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PTRW = AW + 1;

    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    uart_rx_entry_t mem_q [DEPTH];
    uart_rx_entry_t mem_d [DEPTH];
    logic           overrun_q, overrun_d;
    logic           empty, full, do_pop, do_push;

    always_comb begin
        empty     = (wr_q == rd_q);
        full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        wr_d      = wr_q + PTRW'(do_push);
        rd_d      = rd_q + PTRW'(do_pop);
        overrun_d = push && !do_push;
        mem_d     = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign valid   = !empty;
    assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, break detection and
// a receive FIFO. Parity support is built only with UART_RX_PARITY_EN defined.
module uart_rx_os import uart_pkg::*; #(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rx_en,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    uart_rx_os_if.master     m,
    output logic             overrun,
    output logic             busy
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PAYLOAD_BITS + 1);
    localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE/2 - 1);
    localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE/2);
    localparam logic [PW-1:0] PH_S2  = PW'(OVERSAMPLE/2 + 1);
    localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

    uart_rx_state_t          state_q, state_d;
    logic                    rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic [DIV_W-1:0]        tcnt_q, tcnt_d, div_q, div_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [1:0]              samp_q, samp_d;
    logic                    start_q, start_d, ferr_q, ferr_d, sidx_q, sidx_d, busy_q, busy_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    tick, mid, last, m3, perr, par_ok, push, fifo_valid;
    uart_rx_entry_t          entry, head;

`ifdef UART_RX_PARITY_EN
    parity_mode_t pmode_q, pmode_d;
    logic         par_bit_q, par_bit_d, par_en;
    assign par_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    assign perr   = par_en && ((^{shreg_q, par_bit_q}) ^ (pmode_q == PAR_ODD));
    assign par_ok = !(par_en && par_bit_q);
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
    assign perr          = 1'b0;
    assign par_ok        = 1'b1;
`endif

    always_comb begin
        state_d = state_q;  tcnt_d  = tcnt_q;  div_d   = div_q;   phase_d = phase_q;
        samp_d  = samp_q;   start_d = start_q; ferr_d  = ferr_q;  sidx_d  = sidx_q;
        shreg_d = shreg_q;  bcnt_d  = bcnt_q;  push    = 1'b0;    entry   = '0;
`ifdef UART_RX_PARITY_EN
        pmode_d   = pmode_q;
        par_bit_d = par_bit_q;
`endif
        tick = (tcnt_q == div_q);
        mid  = tick && (phase_q == PH_S2);
        last = tick && (phase_q == PH_END);
        m3   = maj3(samp_q[0], samp_q[1], rxd_s2_q);
        entry.data = MAX_PAYLOAD'(shreg_q);
        entry.perr = perr;

        if (state_q != ST_IDLE) begin
            tcnt_d = tick ? '0 : tcnt_q + DIV_W'(1);
            if (tick) phase_d = phase_q + PW'(1);
            if (tick && phase_q == PH_S0) samp_d[0] = rxd_s2_q;
            if (tick && phase_q == PH_S1) samp_d[1] = rxd_s2_q;
        end

        case (state_q)
            ST_IDLE: begin
                tcnt_d  = '0;
                phase_d = '0;
                if (rx_en && rxd_s3_q && !rxd_s2_q) begin
                    state_d = ST_START;
                    div_d   = baud_div;
                    ferr_d  = 1'b0;
                    sidx_d  = 1'b0;
                    shreg_d = '0;
                    bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    pmode_d   = parity_mode_t'(parity_mode);
                    par_bit_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (mid) start_d = m3;
                if (last) state_d = start_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (mid) begin
                    shreg_d = {m3, shreg_q[PAYLOAD_BITS-1:1]};
                    bcnt_d  = bcnt_q + BW'(1);
                end
`ifdef UART_RX_PARITY_EN
                if (last && bcnt_q == BW'(PAYLOAD_BITS)) state_d = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (mid) par_bit_d = m3;
                if (last) state_d = ST_STOP;
`else
                if (last && bcnt_q == BW'(PAYLOAD_BITS)) state_d = ST_STOP;
`endif
            end
            ST_STOP: begin
                // Decide at the mid-sample so the next start edge gets half a bit of margin.
                if (mid) begin
                    if (!sidx_q && !m3 && shreg_q == '0 && par_ok) begin
                        push       = 1'b1;
                        entry.brk  = 1'b1;
                        entry.ferr = 1'b1;
                        state_d    = ST_BRK_WAIT;
                        tcnt_d     = '0;
                        phase_d    = '0;
                    end else if (sidx_q == 1'(STOP_BITS - 1)) begin
                        push       = 1'b1;
                        entry.ferr = ferr_q | !m3;
                        state_d    = ST_IDLE;
                    end else begin
                        ferr_d = ferr_q | !m3;
                        sidx_d = 1'b1;
                    end
                end
            end
            ST_BRK_WAIT: begin
                // Any low sample restarts the full bit of idle-high we wait for.
                if (!rxd_s2_q) begin
                    tcnt_d  = '0;
                    phase_d = '0;
                end else if (last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!rx_en) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            phase_d = '0;
            push    = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rxd_s1_q <= 1'b1;  rxd_s2_q <= 1'b1;  rxd_s3_q <= 1'b1;
            tcnt_q   <= '0;    div_q    <= '0;    phase_q  <= '0;
            samp_q   <= '0;    start_q  <= 1'b0;  ferr_q   <= 1'b0;
            sidx_q   <= 1'b0;  shreg_q  <= '0;    bcnt_q   <= '0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pmode_q   <= PAR_NONE;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rxd_s1_q <= rxd;     rxd_s2_q <= rxd_s1_q;  rxd_s3_q <= rxd_s2_q;
            tcnt_q   <= tcnt_d;  div_q    <= div_d;     phase_q  <= phase_d;
            samp_q   <= samp_d;  start_q  <= start_d;   ferr_q   <= ferr_d;
            sidx_q   <= sidx_d;  shreg_q  <= shreg_d;   bcnt_q   <= bcnt_d;
            busy_q   <= busy_d;
`ifdef UART_RX_PARITY_EN
            pmode_q   <= pmode_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .wdata   (entry),
        .pop     (fifo_valid && m.m_ready),
        .rdata   (head),
        .valid   (fifo_valid),
        .overrun (overrun)
    );

    logic unused_head;
    assign unused_head = ^head.data;

    assign m.m_valid = fifo_valid;
    assign m.m_data  = head.data[PAYLOAD_BITS-1:0];
    assign m.m_perr  = head.perr;
    assign m.m_ferr  = head.ferr;
    assign m.m_break = head.brk;
    assign busy      = busy_q;

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 PAYLOAD_BITS, 8, data bits per frame, legal 5..9.
REQ-002 STOP_BITS, 1, stop bits per frame, legal 1..2.
REQ-003 OVERSAMPLE, 16, oversample ticks per bit, legal 8 or 16.
REQ-004 DIV_W, 16, width of runtime baud divisor.
REQ-005 FIFO_DEPTH, 4, receive FIFO entries, power of 2, >=2.
REQ-006 clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-007 rx_en  in  1  receiver enable.
REQ-008 rxd  in  1  asynchronous serial input, idle high.
REQ-009 baud_div  in  DIV_W  clocks per oversample tick minus 1.
REQ-010 parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 m_valid  out  1  FIFO head valid; m_ready  in  1  consumer accept.
REQ-012 m_data  out  PAYLOAD_BITS  received word, LSB first on line.
REQ-013 m_perr, m_ferr, m_break  out  1 each  status of m_data word.
REQ-014 overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-015 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-016 rxd SHALL pass a 2-flop synchronizer (reset value 1) before any use.
REQ-017 Tick counter SHALL count 0..baud_div and tick on terminal count; baud_div and parity_mode SHALL be latched on IDLE->START and held for the frame.
REQ-018 In IDLE, tick counter and phase counter SHALL be held at 0; synchronized falling edge SHALL enter START.
REQ-019 Bit value SHALL be majority of 3 samples at phases OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; bit ends at phase OVERSAMPLE-1.
REQ-020 States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-021 START majority 1 SHALL return to IDLE (glitch), no FIFO push.
REQ-022 DATA SHALL shift PAYLOAD_BITS bits LSB first, then go to PARITY if parity enabled, else STOP.
REQ-023 m_perr SHALL be set when XOR(data,parity bit) is not 0 (even) or not 1 (odd).
REQ-024 Any stop bit sampled 0 SHALL set m_ferr; word SHALL be pushed on the mid-sample of the last stop bit, then FSM SHALL go to IDLE (half-bit resync margin).
REQ-025 Data all zero, parity bit (if any) 0, and first stop bit 0 SHALL set m_break and m_ferr; FSM SHALL enter BRK_WAIT and stay until synchronized rxd is 1 for one full bit time.
REQ-026 m_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-027 Pop SHALL occur when m_valid && m_ready; m_data/status SHALL be stable while m_valid && !m_ready.
REQ-028 Push when full without simultaneous pop SHALL drop the new word and pulse overrun; push and pop in the same cycle when full SHALL succeed with no overrun.
REQ-029 rx_en low SHALL force FSM to IDLE next cycle, discarding any partial frame; FIFO contents SHALL be unaffected.

Reset
REQ-030 resetn low SHALL set FSM IDLE, all counters 0, FIFO empty, m_valid/m_perr/m_ferr/m_break/overrun/busy 0, m_data 0.
REQ-031 Reset mid-frame SHALL discard the frame with no push.

Configuration
REQ-032 With UART_RX_PARITY_EN defined, parity per REQ-010/023 SHALL be built; without it PARITY state and checker SHALL be absent, parity_mode ignored, m_perr tied 0.

Structure
REQ-033 Package uart_pkg SHALL hold uart_rx_state_t enum, parity_mode_t enum and the FIFO entry struct {break, ferr, perr, data}.
REQ-034 FIFO SHALL be a separate sub-module uart_rx_fifo (synchronous, pointer wrap with extra MSB for full/empty).

Verification
REQ-035 baud_div=1, OVERSAMPLE=16, none parity, send 0xA5 -> m_valid with m_data=0xA5, all status 0, 32 clk/bit.
REQ-036 Odd parity, send 0x03 with parity bit 0 -> m_perr=1, m_data=0x03; parity bit 1 -> m_perr=0.
REQ-037 Stop bit forced 0 on 0x55 -> m_ferr=1, m_break=0; 20 bit times of rxd=0 -> single word m_data=0x00, m_break=1, m_ferr=1, no further push until rxd high for one bit.
REQ-038 m_ready=0, send 5 frames with FIFO_DEPTH=4 -> 4 words held, overrun pulses once, first word unchanged at head.
REQ-039 rxd low pulse of 4 clocks at baud_div=1 -> no push, busy returns low; rx_en dropped mid-frame -> FSM IDLE next cycle, no push.
